// File: rtl/vsc8541_smi_pkg.sv
// Shared types and constants for the VSC8541 Clause-22 SMI frame engine.
package vsc8541_smi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        PRE,
        HDR,
        TA,
        DATA
    } smi_state_e;

    localparam logic [1:0] SMI_ST        = 2'b01;
    localparam logic [1:0] SMI_OP_WR     = 2'b01;
    localparam logic [1:0] SMI_OP_RD     = 2'b10;
    localparam int         SMI_HDR_BITS  = 14;
    localparam int         SMI_DATA_BITS = 16;

    // Header as transmitted MSB-first: ST, OP, PHYAD, REGAD.
    function automatic logic [SMI_HDR_BITS-1:0] smi_header(
        input logic       rw,
        input logic [4:0] phy_addr,
        input logic [4:0] reg_addr
    );
        return {SMI_ST, (rw ? SMI_OP_RD : SMI_OP_WR), phy_addr, reg_addr};
    endfunction

endpackage

// File: rtl/vsc8541_smi_mdc_edge_det.sv
// MDC edge detector: registers MDC in the clk domain and flags rise/fall.
module smi_mdc_edge_det (
    input  logic clk,
    input  logic i_reset,
    input  logic i_mdc,
    output logic o_rise,
    output logic o_fall
);

    logic mdc_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= i_mdc;
        end
    end

    assign o_rise = ~mdc_q & i_mdc;
    assign o_fall = mdc_q & ~i_mdc;

endmodule

// File: rtl/vsc8541_smi_master.sv
// Clause-22 SMI frame engine for the VSC8541 PHY; one MDIO transaction per accepted request.
// Optional VSC8541_SMI_TA_CHECK_EN adds o_rd_err (PHY failed to drive 0 in the second TA bit).
module vsc8541_smi_master
    import vsc8541_smi_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_mdc,
    input  logic        i_start,
    input  logic        i_rw,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rdata,
    output logic        o_mdio_o,
    output logic        o_mdio_oe,
    input  logic        i_mdio_i
`ifdef VSC8541_SMI_TA_CHECK_EN
    ,
    output logic        o_rd_err
`endif
);

    localparam logic [4:0] PRE_LOAD  = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] HDR_LOAD  = 5'(SMI_HDR_BITS - 1);
    localparam logic [4:0] DATA_LOAD = 5'(SMI_DATA_BITS - 1);

    logic mdc_rise;
    logic mdc_fall;

    smi_mdc_edge_det u_edge (
        .clk     (clk),
        .i_reset (i_reset),
        .i_mdc   (i_mdc),
        .o_rise  (mdc_rise),
        .o_fall  (mdc_fall)
    );

    smi_state_e              state_q;
    logic [4:0]              cnt_q;
    logic                    rw_q;
    logic [SMI_HDR_BITS-1:0] hdr_q;
    logic [15:0]             wdata_q;
    logic [15:0]             rdata_sh_q;
    logic [15:0]             rdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    mdio_o_q;
    logic                    mdio_oe_q;
`ifdef VSC8541_SMI_TA_CHECK_EN
    logic                    rd_err_sh_q;
    logic                    rd_err_q;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            hdr_q      <= '0;
            wdata_q    <= '0;
            rdata_sh_q <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mdio_o_q   <= 1'b1;
            mdio_oe_q  <= 1'b0;
`ifdef VSC8541_SMI_TA_CHECK_EN
            rd_err_sh_q <= 1'b0;
            rd_err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            // The PHY drives read data on MDC rise; sample it on the next rise.
            if (mdc_rise && state_q == DATA) begin
                rdata_sh_q <= {rdata_sh_q[14:0], i_mdio_i};
            end
`ifdef VSC8541_SMI_TA_CHECK_EN
            if (mdc_rise && state_q == TA && cnt_q == '0 && rw_q) begin
                rd_err_sh_q <= i_mdio_i;
            end
`endif

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        rw_q    <= i_rw;
                        hdr_q   <= smi_header(i_rw, i_phy_addr, i_reg_addr);
                        wdata_q <= i_wdata;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_FALL;
`ifdef VSC8541_SMI_TA_CHECK_EN
                        rd_err_q <= 1'b0;
`endif
                    end
                end
                WAIT_FALL: begin
                    if (mdc_fall) begin
                        mdio_oe_q <= 1'b1;
                        mdio_o_q  <= 1'b1;
                        cnt_q     <= PRE_LOAD;
                        state_q   <= PRE;
                    end
                end
                PRE: begin
                    if (mdc_fall) begin
                        if (cnt_q == '0) begin
                            mdio_o_q <= hdr_q[SMI_HDR_BITS-1];
                            hdr_q    <= {hdr_q[SMI_HDR_BITS-2:0], 1'b0};
                            cnt_q    <= HDR_LOAD;
                            state_q  <= HDR;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                HDR: begin
                    if (mdc_fall) begin
                        if (cnt_q == '0) begin
                            // Read releases the line for the whole turnaround.
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= ~rw_q;
                            cnt_q     <= 5'd1;
                            state_q   <= TA;
                        end else begin
                            mdio_o_q <= hdr_q[SMI_HDR_BITS-1];
                            hdr_q    <= {hdr_q[SMI_HDR_BITS-2:0], 1'b0};
                            cnt_q    <= cnt_q - 5'd1;
                        end
                    end
                end
                TA: begin
                    if (mdc_fall) begin
                        if (cnt_q == '0) begin
                            mdio_o_q <= rw_q | wdata_q[15];
                            wdata_q  <= {wdata_q[14:0], 1'b0};
                            cnt_q    <= DATA_LOAD;
                            state_q  <= DATA;
                        end else begin
                            mdio_o_q <= rw_q;
                            cnt_q    <= cnt_q - 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (mdc_fall) begin
                        if (cnt_q == '0) begin
                            mdio_oe_q <= 1'b0;
                            mdio_o_q  <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                            if (rw_q) begin
                                rdata_q <= rdata_sh_q;
                            end
`ifdef VSC8541_SMI_TA_CHECK_EN
                            if (rw_q) begin
                                rd_err_q <= rd_err_sh_q;
                            end
`endif
                        end else begin
                            mdio_o_q <= rw_q | wdata_q[15];
                            wdata_q  <= {wdata_q[14:0], 1'b0};
                            cnt_q    <= cnt_q - 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rdata   = rdata_q;
    assign o_mdio_o  = mdio_o_q;
    assign o_mdio_oe = mdio_oe_q;
`ifdef VSC8541_SMI_TA_CHECK_EN
    assign o_rd_err  = rd_err_q;
`endif

endmodule

// File: tb/tb_vsc8541_smi_master.sv
// Directed bench for vsc8541_smi_master: MDC period 8 clk, PHY model on MDC edges.
module tb_vsc8541_smi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        mdc0 = 1'b0, mdc1 = 1'b0;
    logic [2:0]  mc0 = 3'd0, mc1 = 3'd0;
    logic        stall1 = 1'b0;

    logic        start0 = 1'b0, rw0 = 1'b0;
    logic [4:0]  phy0 = '0, reg0 = '0;
    logic [15:0] wdata0 = '0;
    logic        busy0, done0, o0, oe0, mdio_i0;
    logic [15:0] rdata0;

    logic        start1 = 1'b0, rw1 = 1'b0;
    logic [4:0]  phy1 = '0, reg1 = '0;
    logic [15:0] wdata1 = '0;
    logic        busy1, done1, o1, oe1, mdio_i1;
    logic [15:0] rdata1;
`ifdef VSC8541_SMI_TA_CHECK_EN
    logic        rd_err0, rd_err1;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt0 = 0, done_cnt1 = 0;

    int          rec_n = 0, rec1_n = 0;
    logic [63:0] rec_o = '0, rec_oe = '0, rec1_o = '0, rec1_oe = '0;
    bit          started = 0, started1 = 0;

    logic        phy_d = 1'b1;
    bit          phy_en = 0;
    logic [15:0] phy_data = '0;
    logic        ta_val = 1'b0;

    vsc8541_smi_master #(.PREAMBLE_LEN(32)) dut (
        .clk(clk), .i_reset(rst), .i_mdc(mdc0), .i_start(start0), .i_rw(rw0),
        .i_phy_addr(phy0), .i_reg_addr(reg0), .i_wdata(wdata0),
        .o_busy(busy0), .o_done(done0), .o_rdata(rdata0),
        .o_mdio_o(o0), .o_mdio_oe(oe0), .i_mdio_i(mdio_i0)
`ifdef VSC8541_SMI_TA_CHECK_EN
        , .o_rd_err(rd_err0)
`endif
    );

    vsc8541_smi_master #(.PREAMBLE_LEN(1)) dut1 (
        .clk(clk), .i_reset(rst), .i_mdc(mdc1), .i_start(start1), .i_rw(rw1),
        .i_phy_addr(phy1), .i_reg_addr(reg1), .i_wdata(wdata1),
        .o_busy(busy1), .o_done(done1), .o_rdata(rdata1),
        .o_mdio_o(o1), .o_mdio_oe(oe1), .i_mdio_i(mdio_i1)
`ifdef VSC8541_SMI_TA_CHECK_EN
        , .o_rd_err(rd_err1)
`endif
    );

    // MDC sources, 4 clk high / 4 clk low; dut1's can be frozen low.
    always @(posedge clk) begin
        mc0  <= mc0 + 3'd1;
        mdc0 <= mc0[2];
    end
    always @(posedge clk) begin
        if (!(stall1 && !mdc1)) begin
            mc1  <= mc1 + 3'd1;
            mdc1 <= mc1[2];
        end
    end

    assign mdio_i0 = oe0 ? o0 : phy_d;
    assign mdio_i1 = oe1 ? o1 : 1'b1;

    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    // Line recorders: one bit per MDC rise, from the first driven bit of a frame.
    always @(posedge mdc0) begin
        #1;
        if (!busy0) started = 0;
        else if (started || oe0) begin
            if (!started) begin rec_n = 0; rec_o = '0; rec_oe = '0; end
            started = 1;
            rec_o  = {rec_o[62:0], o0};
            rec_oe = {rec_oe[62:0], oe0};
            rec_n++;
        end
    end
    always @(posedge mdc1) begin
        #1;
        if (!busy1) started1 = 0;
        else if (started1 || oe1) begin
            if (!started1) begin rec1_n = 0; rec1_o = '0; rec1_oe = '0; end
            started1 = 1;
            rec1_o  = {rec1_o[62:0], o1};
            rec1_oe = {rec1_oe[62:0], oe1};
            rec1_n++;
        end
    end

    // PHY: drives the bit whose index equals the number of bits already seen.
    always @(negedge mdc0) begin
        #1;
        if (phy_en && started && rec_n == 47) phy_d = ta_val;
        else if (phy_en && started && rec_n >= 48 && rec_n <= 63) phy_d = phy_data[4'(63 - rec_n)];
        else phy_d = 1'b1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req0(input logic rw, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        @(negedge clk);
        rw0 = rw; phy0 = pa; reg0 = ra; wdata0 = wd; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        bit seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        check_val({tag, " done seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check_val({tag, " busy at done"}, 64'(busy0), 64'd0);
            check_val({tag, " oe at done"}, 64'(oe0), 64'd0);
            check_val({tag, " mdio at done"}, 64'(o0), 64'd1);
        end
    endtask

    initial begin
        int  c0, c1, snap_n;
        logic snap_o, snap_oe;
        bit  seen;

        repeat (5) @(negedge clk);
        check_val("rst busy", 64'(busy0), 64'd0);
        check_val("rst done", 64'(done0), 64'd0);
        check_val("rst rdata", 64'(rdata0), 64'd0);
        check_val("rst mdio_o", 64'(o0), 64'd1);
        check_val("rst mdio_oe", 64'(oe0), 64'd0);
`ifdef VSC8541_SMI_TA_CHECK_EN
        check_val("rst rd_err", 64'(rd_err0), 64'd0);
`endif
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: write phy 0x00 reg 0x1F data 0x0010
        c0 = done_cnt0;
        req0(1'b0, 5'h00, 5'h1F, 16'h0010);
        wait_done0("wr1");
        check_val("wr1 bits", 64'(rec_n), 64'd64);
        check_val("wr1 mdio", rec_o, 64'hFFFF_FFFF_507E_0010);
        check_val("wr1 oe", rec_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) @(negedge clk);
        check_val("wr1 done count", 64'(done_cnt0 - c0), 64'd1);
        check_val("wr1 rdata kept", 64'(rdata0), 64'd0);

        // 2: read phy 0x01 reg 0x02, PHY returns 0x0007 with TA bit2 = 0
        phy_en = 1; phy_data = 16'h0007; ta_val = 1'b0;
        req0(1'b1, 5'h01, 5'h02, 16'h0000);
        wait_done0("rd2");
        check_val("rd2 rdata", 64'(rdata0), 64'h0007);
        check_val("rd2 oe", rec_oe, 64'hFFFF_FFFF_FFFC_0000);
        check_val("rd2 header", 64'(rec_o[31:18]), 64'(14'b01100000100010));
`ifdef VSC8541_SMI_TA_CHECK_EN
        check_val("rd2 rd_err", 64'(rd_err0), 64'd0);
`endif

        // 3: read with nobody driving; pull-up gives all ones
        phy_en = 0;
        req0(1'b1, 5'h01, 5'h02, 16'h0000);
        wait_done0("rd3");
        check_val("rd3 rdata", 64'(rdata0), 64'hFFFF);
`ifdef VSC8541_SMI_TA_CHECK_EN
        check_val("rd3 rd_err", 64'(rd_err0), 64'd1);
`endif

        // 4: start held every clk during a write; only the first request counts
        repeat (20) @(negedge clk);
        c0 = done_cnt0;
        rw0 = 1'b0; phy0 = 5'h15; reg0 = 5'h0A; wdata0 = 16'hA5C3; start0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1;
                check_val("wr4 busy at done", 64'(busy0), 64'd0);
                start0 = 1'b0;
            end else begin
                phy0 = 5'(i); reg0 = 5'(i + 7); wdata0 = 16'(i * 3); rw0 = i[0];
            end
        end
        start0 = 1'b0;
        check_val("wr4 done seen", 64'(seen), 64'd1);
        repeat (100) @(negedge clk);
        check_val("wr4 done count", 64'(done_cnt0 - c0), 64'd1);
        check_val("wr4 busy after", 64'(busy0), 64'd0);
        check_val("wr4 bits", 64'(rec_n), 64'd64);
        check_val("wr4 mdio", rec_o, 64'hFFFF_FFFF_5AAA_A5C3);
        check_val("wr4 rdata kept", 64'(rdata0), 64'hFFFF);

        // 5: reset during data bit 5, then a clean frame
        c0 = done_cnt0;
        req0(1'b0, 5'h02, 5'h03, 16'hBEEF);
        seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (started && rec_n >= 54) seen = 1;
        end
        check_val("rst5 reached data", 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst5 oe", 64'(oe0), 64'd0);
        check_val("rst5 mdio", 64'(o0), 64'd1);
        check_val("rst5 busy", 64'(busy0), 64'd0);
        check_val("rst5 rdata cleared", 64'(rdata0), 64'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check_val("rst5 no done", 64'(done_cnt0 - c0), 64'd0);
        check_val("rst5 idle", 64'(busy0), 64'd0);
        req0(1'b0, 5'h1C, 5'h05, 16'h8001);
        wait_done0("wr5");
        check_val("wr5 bits", 64'(rec_n), 64'd64);
        check_val("wr5 mdio", rec_o, 64'hFFFF_FFFF_5E16_8001);
        check_val("wr5 oe", rec_oe, 64'hFFFF_FFFF_FFFF_FFFF);

        // 6: PREAMBLE_LEN=1 instance, MDC frozen low mid-header
        c1 = done_cnt1;
        @(negedge clk);
        rw1 = 1'b0; phy1 = 5'h03; reg1 = 5'h11; wdata1 = 16'h1234; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (started1 && rec1_n >= 6) seen = 1;
        end
        check_val("st6 reached hdr", 64'(seen), 64'd1);
        stall1 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!mdc1) seen = 1;
        end
        check_val("st6 mdc low", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        snap_o = o1; snap_oe = oe1; snap_n = rec1_n;
        repeat (100) @(negedge clk);
        check_val("st6 mdio frozen", 64'(o1), 64'(snap_o));
        check_val("st6 oe frozen", 64'(oe1), 64'(snap_oe));
        check_val("st6 still busy", 64'(busy1), 64'd1);
        check_val("st6 no early done", 64'(done_cnt1 - c1), 64'd0);
        check_val("st6 no bits", 64'(rec1_n), 64'(snap_n));
        stall1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (done1) seen = 1;
        end
        check_val("st6 done seen", 64'(seen), 64'd1);
        check_val("st6 bits", 64'(rec1_n), 64'd33);
        check_val("st6 mdio", 64'(rec1_o[32:0]), 64'h1_51C6_1234);
        check_val("st6 oe", 64'(rec1_oe[32:0]), 64'h1_FFFF_FFFF);
        repeat (3) @(negedge clk);
        check_val("st6 done count", 64'(done_cnt1 - c1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
